// File: rtl/plic_claim_engine_pkg.sv
// Shared types for the PLIC claim/complete sequencer: per-target and APB
// master state encodings plus the holdoff counter width.
package plic_claim_pkg;

    localparam int HOLDOFF_W = 4;
    localparam int TSTATE_W  = 3;
    localparam int ASTATE_W  = 2;

    typedef enum logic [TSTATE_W-1:0] {
        T_IDLE      = 3'd0,
        T_CLAIM_REQ = 3'd1,
        T_OFFER     = 3'd2,
        T_SERVICE   = 3'd3,
        T_CMPL_REQ  = 3'd4
    } tgt_state_e;

    typedef enum logic [ASTATE_W-1:0] {
        A_IDLE   = 2'd0,
        A_SETUP  = 2'd1,
        A_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/plic_claim_engine_if.sv
// APB4 bus between the claim engine (master) and the PLIC register file (slave).
interface plic_claim_engine_if #(
    parameter int PADDR_SIZE = 32,
    parameter int PDATA_SIZE = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic                    PWRITE;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/plic_claim_engine_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves to one past the winner when the grant is accepted.
module plic_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_accept,
    output logic [N-1:0] o_grant
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_j;
    logic [IW:0]   w_sum;
    logic          w_found;

    // One extra bit on the sum keeps ptr+k exact before the modulo-N wrap.
    always_comb begin
        o_grant = '0;
        w_idx   = r_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_j = w_sum[IW-1:0];
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                w_idx      = w_j;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_accept && w_found) begin
            r_ptr <= (w_idx == IW'(N-1)) ? '0 : w_idx + IW'(1);
        end
    end

endmodule

// File: rtl/plic_claim_engine.sv
// Hardware claim/complete sequencer for the APB4 PLIC: claims IDs for targets
// with pending irq, offers them to consumers and writes them back when done.
module plic_claim_engine
    import plic_claim_pkg::*;
#(
    parameter int          PADDR_SIZE   = 32,
    parameter int          PDATA_SIZE   = 32,
    parameter int          SOURCES      = 64,
    parameter int          TARGETS      = 4,
    parameter logic [31:0] CLAIM_BASE   = 32'h0020_0004,
    parameter logic [31:0] CLAIM_STRIDE = 32'h0000_1000,
    parameter int          HOLDOFF      = 2,
    localparam int         SOURCES_BITS = $clog2(SOURCES + 1)
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [TARGETS-1:0]               irq,
    plic_claim_engine_if.master              apb,
    // id_valid/id_ready: id[t] is held stable while id_valid[t] is high and the
    // ID is handed over on the cycle both id_valid[t] and id_ready[t] are high.
    output logic [TARGETS-1:0]               id_valid,
    output logic [TARGETS*SOURCES_BITS-1:0]  id,
    input  logic [TARGETS-1:0]               id_ready,
    input  logic [TARGETS-1:0]               done,
    output logic [ASTATE_W-1:0]              o_dbg_apb_state,
    output logic [TARGETS*TSTATE_W-1:0]      o_dbg_tgt_state
);
    localparam int TIW = (TARGETS > 1) ? $clog2(TARGETS) : 1;
    localparam logic [HOLDOFF_W-1:0] HOLDOFF_LOAD = HOLDOFF_W'(HOLDOFF);

    tgt_state_e              r_tstate  [TARGETS];
    logic [SOURCES_BITS-1:0] r_id      [TARGETS];
    logic [HOLDOFF_W-1:0]    r_holdoff [TARGETS];

    apb_state_e              r_astate;
    logic [TIW-1:0]          r_owner;
    logic                    r_pwrite;
    logic [PADDR_SIZE-1:0]   r_paddr;
    logic [PDATA_SIZE-1:0]   r_pwdata;
    logic [PDATA_SIZE/8-1:0] r_pstrb;

    logic [TARGETS-1:0]      w_cmpl_req;
    logic [TARGETS-1:0]      w_claim_req;
    logic [TARGETS-1:0]      w_cmpl_grant;
    logic [TARGETS-1:0]      w_claim_grant;
    logic [TARGETS-1:0]      w_grant;
    logic [TIW-1:0]          w_gidx;
    logic [PADDR_SIZE-1:0]   w_addr;
    logic                    w_cmpl_any;
    logic                    w_claim_any;
    logic                    w_apb_idle;
    logic                    w_start;
    logic                    w_xfer_done;
    logic                    w_rd_ok;
    logic [SOURCES_BITS-1:0] w_rd_id;
    logic                    w_unused_prdata;

    always_comb begin
        w_cmpl_req  = '0;
        w_claim_req = '0;
        for (int t = 0; t < TARGETS; t++) begin
            w_cmpl_req[t]  = (r_tstate[t] == T_CMPL_REQ);
            w_claim_req[t] = (r_tstate[t] == T_CLAIM_REQ);
        end
    end

    // While a transfer is outstanding the requester's state is unchanged, but
    // no grant can be issued because arbitration only happens in A_IDLE.
    assign w_apb_idle  = (r_astate == A_IDLE);
    assign w_cmpl_any  = |w_cmpl_req;
    assign w_claim_any = |w_claim_req;
    assign w_start     = w_apb_idle && (w_cmpl_any || w_claim_any);
    assign w_grant     = w_cmpl_any ? w_cmpl_grant : w_claim_grant;

    plic_rr_arbiter #(.N(TARGETS)) u_cmpl_arb (
        .i_clk    (PCLK),
        .i_rst    (PRESET),
        .i_req    (w_cmpl_req),
        .i_accept (w_apb_idle && w_cmpl_any),
        .o_grant  (w_cmpl_grant)
    );

    plic_rr_arbiter #(.N(TARGETS)) u_claim_arb (
        .i_clk    (PCLK),
        .i_rst    (PRESET),
        .i_req    (w_claim_req),
        .i_accept (w_apb_idle && !w_cmpl_any && w_claim_any),
        .o_grant  (w_claim_grant)
    );

    always_comb begin
        w_gidx = '0;
        for (int t = 0; t < TARGETS; t++) begin
            if (w_grant[t]) begin
                w_gidx = TIW'(t);
            end
        end
    end

    assign w_addr = PADDR_SIZE'(CLAIM_BASE)
                  + PADDR_SIZE'(w_gidx) * PADDR_SIZE'(CLAIM_STRIDE);

    assign w_xfer_done     = (r_astate == A_ACCESS) && apb.PREADY;
    assign w_rd_id         = apb.PRDATA[SOURCES_BITS-1:0];
    assign w_rd_ok         = !apb.PSLVERR && (w_rd_id != '0);
    assign w_unused_prdata = ^apb.PRDATA;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_astate <= A_IDLE;
            r_owner  <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else begin
            case (r_astate)
                A_IDLE: begin
                    if (w_start) begin
                        r_astate <= A_SETUP;
                        r_owner  <= w_gidx;
                        r_pwrite <= w_cmpl_any;
                        r_paddr  <= w_addr;
                        r_pwdata <= w_cmpl_any ? PDATA_SIZE'(r_id[w_gidx]) : '0;
                        r_pstrb  <= w_cmpl_any ? '1 : '0;
                    end
                end
                A_SETUP: begin
                    r_astate <= A_ACCESS;
                end
                A_ACCESS: begin
                    if (apb.PREADY) begin
                        r_astate <= A_IDLE;
                    end
                end
                default: begin
                    r_astate <= A_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int t = 0; t < TARGETS; t++) begin
                r_tstate[t]  <= T_IDLE;
                r_id[t]      <= '0;
                r_holdoff[t] <= '0;
            end
        end else begin
            for (int t = 0; t < TARGETS; t++) begin
                case (r_tstate[t])
                    T_IDLE: begin
                        if (r_holdoff[t] != '0) begin
                            r_holdoff[t] <= r_holdoff[t] - HOLDOFF_W'(1);
                        end else if (irq[t]) begin
                            r_tstate[t] <= T_CLAIM_REQ;
                        end
                    end
                    T_CLAIM_REQ: begin
                        // A zero ID or a slave error is a spurious claim.
                        if (w_xfer_done && (r_owner == TIW'(t))) begin
                            if (w_rd_ok) begin
                                r_id[t]     <= w_rd_id;
                                r_tstate[t] <= T_OFFER;
                            end else begin
                                r_tstate[t] <= T_IDLE;
                            end
                        end
                    end
                    T_OFFER: begin
                        if (id_ready[t]) begin
                            r_tstate[t] <= T_SERVICE;
                        end
                    end
                    T_SERVICE: begin
                        if (done[t]) begin
                            r_tstate[t] <= T_CMPL_REQ;
                        end
                    end
                    T_CMPL_REQ: begin
                        if (w_xfer_done && (r_owner == TIW'(t))) begin
                            r_tstate[t]  <= T_IDLE;
                            r_holdoff[t] <= HOLDOFF_LOAD;
                        end
                    end
                    default: begin
                        r_tstate[t] <= T_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        id_valid        = '0;
        id              = '0;
        o_dbg_tgt_state = '0;
        for (int t = 0; t < TARGETS; t++) begin
            id_valid[t]                              = (r_tstate[t] == T_OFFER);
            id[t*SOURCES_BITS +: SOURCES_BITS]       = r_id[t];
            o_dbg_tgt_state[t*TSTATE_W +: TSTATE_W]  = r_tstate[t];
        end
    end

    assign apb.PSEL        = (r_astate != A_IDLE);
    assign apb.PENABLE     = (r_astate == A_ACCESS);
    assign apb.PADDR       = r_paddr;
    assign apb.PWRITE      = r_pwrite;
    assign apb.PSTRB       = r_pstrb;
    assign apb.PWDATA      = r_pwdata;
    assign o_dbg_apb_state = r_astate;

endmodule

// File: tb/tb_plic_claim_engine.sv
// Directed bench for plic_claim_engine: a vector table of single claim/complete
// rounds plus hand sequences for arbitration, holdoff and mid-transfer reset.
module tb_plic_claim_engine;
    import plic_claim_pkg::*;

    localparam int SB = 7;

    typedef struct {
        int          tgt;
        logic [31:0] rdata;
        logic        rd_err;
        logic        wr_err;
        int          waits;
        logic [31:0] addr;
        logic        valid;
        logic [6:0]  exp_id;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic [3:0]  id_valid;
    logic [27:0] id;
    logic [3:0]  id_ready;
    logic [3:0]  done;
    logic [1:0]  dbg_apb;
    logic [11:0] dbg_tgt;

    int          n_pass  = 0;
    int          n_total = 0;
    int          lat;
    int          n;
    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [6:0]  claim_ids[4];

    plic_claim_engine_if #(.PADDR_SIZE(32), .PDATA_SIZE(32)) bus ();

    plic_claim_engine dut (
        .PCLK            (clk),
        .PRESET          (rst),
        .irq             (irq),
        .apb             (bus),
        .id_valid        (id_valid),
        .id              (id),
        .id_ready        (id_ready),
        .done            (done),
        .o_dbg_apb_state (dbg_apb),
        .o_dbg_tgt_state (dbg_tgt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [6:0] id_of(input int t);
        return id[t*SB +: SB];
    endfunction

    function automatic logic [2:0] st_of(input int t);
        return dbg_tgt[t*3 +: 3];
    endfunction

    // Acts as the PLIC slave for one transfer; returns the number of cycles
    // from call until PSEL was seen.
    task automatic apb_serve(input string tag, input int waits, input logic [31:0] rdata,
                             input logic err, input logic [31:0] e_addr, input logic e_wr,
                             input logic [31:0] e_wdata, input logic [3:0] e_strb,
                             output int lat_o);
        lat_o = 0;
        while (bus.PSEL !== 1'b1 && lat_o < 40) begin
            @(negedge clk);
            lat_o++;
        end
        if (bus.PSEL !== 1'b1) begin
            check({tag, ".start"}, bus.PSEL, 1);
            return;
        end
        check({tag, ".setup_penable"}, bus.PENABLE, 0);
        check({tag, ".addr"},  bus.PADDR,  e_addr);
        check({tag, ".write"}, bus.PWRITE, e_wr);
        check({tag, ".wdata"}, bus.PWDATA, e_wdata);
        check({tag, ".strb"},  bus.PSTRB,  e_strb);
        @(negedge clk);
        check({tag, ".access_psel"},    bus.PSEL,    1);
        check({tag, ".access_penable"}, bus.PENABLE, 1);
        for (int i = 0; i < waits; i++) begin
            bus.PREADY = 1'b0;
            bus.PRDATA = 32'hFFFF_FFFF;
            @(negedge clk);
            check({tag, ".wait_penable"}, bus.PENABLE, 1);
            check({tag, ".wait_addr"},    bus.PADDR,   e_addr);
            check({tag, ".wait_write"},   bus.PWRITE,  e_wr);
            check({tag, ".wait_wdata"},   bus.PWDATA,  e_wdata);
        end
        bus.PREADY  = 1'b1;
        bus.PRDATA  = rdata;
        bus.PSLVERR = err;
        @(negedge clk);
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        check({tag, ".end_psel"},    bus.PSEL,    0);
        check({tag, ".end_penable"}, bus.PENABLE, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        irq         = '0;
        id_ready    = '0;
        done        = '0;
        bus.PRDATA  = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;

        vecs[0] = '{3, 32'h0000_002A, 1'b0, 1'b1, 0, 32'h0020_3004, 1'b1, 7'h2A};
        vecs[1] = '{0, 32'h0000_0040, 1'b0, 1'b0, 3, 32'h0020_0004, 1'b1, 7'h40};
        vecs[2] = '{2, 32'h0000_0011, 1'b1, 1'b0, 1, 32'h0020_2004, 1'b0, 7'h00};
        vecs[3] = '{1, 32'h0000_0000, 1'b0, 1'b0, 0, 32'h0020_1004, 1'b0, 7'h00};
        vecs[4] = '{2, 32'h0000_0187, 1'b0, 1'b0, 0, 32'h0020_2004, 1'b1, 7'h07};
        vecs[5] = '{1, 32'h0000_007F, 1'b0, 1'b0, 2, 32'h0020_1004, 1'b1, 7'h7F};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst.psel",     bus.PSEL,    0);
        check("rst.penable",  bus.PENABLE, 0);
        check("rst.paddr",    bus.PADDR,   0);
        check("rst.pwrite",   bus.PWRITE,  0);
        check("rst.pstrb",    bus.PSTRB,   0);
        check("rst.pwdata",   bus.PWDATA,  0);
        check("rst.id_valid", id_valid,    0);
        check("rst.id",       id,          0);
        check("rst.apb_st",   dbg_apb,     A_IDLE);
        check("rst.tgt_st",   dbg_tgt,     0);
        rst = 1'b0;
        @(negedge clk);

        // Basic round on target 1 with ID 5
        irq = 4'b0010;
        apb_serve("t1.claim", 0, 32'd5, 1'b0, 32'h0020_1004, 1'b0, 32'h0, 4'h0, lat);
        check("t1.claim_lat", lat, 2);
        check("t1.id_valid", id_valid, 4'b0010);
        check("t1.id", id_of(1), 7'd5);
        done = 4'b0010;
        @(negedge clk);
        done = '0;
        check("t1.done_ignored_in_offer", st_of(1), T_OFFER);
        @(negedge clk);
        check("t1.hold_valid", id_valid, 4'b0010);
        check("t1.hold_id", id_of(1), 7'd5);
        id_ready = 4'b0010;
        @(negedge clk);
        id_ready = '0;
        check("t1.valid_drop", id_valid, 4'b0000);
        check("t1.service", st_of(1), T_SERVICE);
        done = 4'b0010;
        @(negedge clk);
        done = '0;
        check("t1.cmpl_req", st_of(1), T_CMPL_REQ);
        apb_serve("t1.cmpl", 0, 32'h0, 1'b0, 32'h0020_1004, 1'b1, 32'd5, 4'hF, lat);
        check("t1.cmpl_lat", lat, 1);
        check("t1.idle_after_cmpl", st_of(1), T_IDLE);

        // irq still high: re-claim only after the holdoff; zero read is spurious
        apb_serve("t4.reclaim", 0, 32'h0, 1'b0, 32'h0020_1004, 1'b0, 32'h0, 4'h0, lat);
        check("t4.holdoff_lat", lat, HOLDOFF_W'(2) + 2);
        check("t4.zero_no_valid", id_valid, 4'b0000);
        check("t4.zero_idle", st_of(1), T_IDLE);
        apb_serve("t4.slverr", 0, 32'd9, 1'b1, 32'h0020_1004, 1'b0, 32'h0, 4'h0, lat);
        check("t4.spurious_lat", lat, 2);
        irq = '0;
        check("t4.slverr_no_valid", id_valid, 4'b0000);
        repeat (3) @(negedge clk);

        // Vector table: one claim (and complete when valid) per row
        for (int i = 0; i < 6; i++) begin
            irq[vecs[i].tgt] = 1'b1;
            apb_serve($sformatf("vec%0d.claim", i), vecs[i].waits, vecs[i].rdata,
                      vecs[i].rd_err, vecs[i].addr, 1'b0, 32'h0, 4'h0, lat);
            irq = '0;
            check($sformatf("vec%0d.claim_lat", i), lat, 2);
            check($sformatf("vec%0d.id_valid", i), id_valid, 4'(vecs[i].valid) << vecs[i].tgt);
            if (vecs[i].valid) begin
                check($sformatf("vec%0d.id", i), id_of(vecs[i].tgt), vecs[i].exp_id);
                id_ready[vecs[i].tgt] = 1'b1;
                @(negedge clk);
                id_ready = '0;
                done[vecs[i].tgt] = 1'b1;
                @(negedge clk);
                done = '0;
                apb_serve($sformatf("vec%0d.cmpl", i), vecs[i].waits, 32'hDEAD_BEEF,
                          vecs[i].wr_err, vecs[i].addr, 1'b1, {25'd0, vecs[i].exp_id},
                          4'hF, lat);
            end
            check($sformatf("vec%0d.idle", i), st_of(vecs[i].tgt), T_IDLE);
            repeat (4) @(negedge clk);
        end

        // Simultaneous claims after reset: round-robin order 0, 2, 3
        do_reset();
        claim_ids[0] = 7'h0A;
        claim_ids[1] = 7'h00;
        claim_ids[2] = 7'h0C;
        claim_ids[3] = 7'h0D;
        exp_q.push_back(32'h0020_0004);
        exp_q.push_back(32'h0020_2004);
        exp_q.push_back(32'h0020_3004);
        irq = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            exp_addr = exp_q.pop_front();
            apb_serve($sformatf("rr.claim%0d", k), 0, {25'd0, claim_ids[exp_addr[13:12]]},
                      1'b0, exp_addr, 1'b0, 32'h0, 4'h0, lat);
            check($sformatf("rr.claim%0d_lat", k), lat, (k == 0) ? 2 : 1);
        end
        irq = '0;
        check("rr.id_valid", id_valid, 4'b1101);
        check("rr.id0", id_of(0), 7'h0A);
        check("rr.id2", id_of(2), 7'h0C);
        check("rr.id3", id_of(3), 7'h0D);
        id_ready = 4'b1101;
        @(negedge clk);
        id_ready = '0;
        check("rr.accepted", id_valid, 4'b0000);
        done = 4'b1001;
        @(negedge clk);
        done = '0;
        apb_serve("rr.cmpl0", 0, 32'h0, 1'b0, 32'h0020_0004, 1'b1, 32'h0A, 4'hF, lat);
        apb_serve("rr.cmpl3", 0, 32'h0, 1'b0, 32'h0020_3004, 1'b1, 32'h0D, 4'hF, lat);
        check("rr.cmpl3_lat", lat, 1);
        repeat (4) @(negedge clk);

        // Complete on target 2 beats a concurrent claim on target 0
        done = 4'b0100;
        irq  = 4'b0001;
        @(negedge clk);
        done = '0;
        check("prio.both_req", {st_of(2), st_of(0)}, {T_CMPL_REQ, T_CLAIM_REQ});
        apb_serve("prio.cmpl2", 0, 32'h0, 1'b0, 32'h0020_2004, 1'b1, 32'h0C, 4'hF, lat);
        apb_serve("prio.claim0", 0, 32'h15, 1'b0, 32'h0020_0004, 1'b0, 32'h0, 4'h0, lat);
        check("prio.claim0_lat", lat, 1);
        irq = '0;
        check("prio.id_valid", id_valid, 4'b0001);
        check("prio.id0", id_of(0), 7'h15);

        // Reset in the middle of an ACCESS phase
        do_reset();
        irq = 4'b0010;
        n = 0;
        while (bus.PSEL !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rstmid.start", bus.PSEL, 1);
        @(negedge clk);
        check("rstmid.access", bus.PENABLE, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.psel",     bus.PSEL,    0);
        check("rstmid.penable",  bus.PENABLE, 0);
        check("rstmid.id_valid", id_valid,    0);
        check("rstmid.apb_st",   dbg_apb,     A_IDLE);
        check("rstmid.tgt_st",   dbg_tgt,     0);
        rst = 1'b0;
        apb_serve("rstmid.reclaim", 0, 32'h33, 1'b0, 32'h0020_1004, 1'b0, 32'h0, 4'h0, lat);
        check("rstmid.reclaim_lat", lat, 2);
        irq = '0;
        check("rstmid.id_valid_after", id_valid, 4'b0010);
        check("rstmid.id_after", id_of(1), 7'h33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/plic_claim_engine.md
Name: plic_claim_engine

Overview:
- Hardware claim/complete sequencer for the APB4 PLIC.
- Watches the PLIC `irq` lines (one per target) and arbitrates between targets for a single APB4 master port.
- Reads a target's claim register to obtain the interrupt ID and hands it to that target's consumer over a valid/ready handshake.
- After the consumer signals done, writes the ID back to the same register to complete it. This offloads claim/complete bus traffic from the hart.

Parameters:
- PADDR_SIZE, 32, APB address width
- PDATA_SIZE, 32, APB data width
- SOURCES, 64, number of PLIC sources; sets ID width
- TARGETS, 4, number of PLIC targets handled
- CLAIM_BASE, 32'h0020_0004, claim/complete register address of target 0
- CLAIM_STRIDE, 32'h0000_1000, address step between targets
- HOLDOFF, 2, idle cycles after a complete before that target may claim again (0..15)

Ports:
- PCLK  in  1  clock, rising edge
- PRESET  in  1  reset, synchronous, active-high
- irq  in  TARGETS  interrupt requests from the PLIC
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  PADDR_SIZE  APB address
- PWRITE  out  1  APB direction
- PSTRB  out  PDATA_SIZE/8  byte strobes
- PWDATA  out  PDATA_SIZE  write data
- PRDATA  in  PDATA_SIZE  read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- id_valid  out  TARGETS  claimed ID available for target t
- id  out  TARGETS*SOURCES_BITS  claimed ID; target t occupies slice t; SOURCES_BITS = $clog2(SOURCES+1)
- id_ready  in  TARGETS  consumer accepts id
- done  in  TARGETS  single-cycle pulse: consumer finished servicing

Behaviour:
- Clock and reset: one clock, PCLK. Reset is PRESET, synchronous, active-high.
- Reset values: all outputs 0; every target state IDLE; APB FSM IDLE; arbiter pointers at 0; holdoff counters 0.
- Reset mid-transfer: PSEL/PENABLE drop at the next edge and any claimed ID is discarded. The system must reset the PLIC together with this block.

Per-target FSM:
- T_IDLE -> T_CLAIM_REQ when irq[t]=1 and holdoff[t]=0.
- T_CLAIM_REQ: waits for the grant, then the APB read completes.
  - Read data 0 or PSLVERR=1 -> T_IDLE. This is a spurious claim; id_valid never asserts.
  - Otherwise latch PRDATA[SOURCES_BITS-1:0] and go to T_OFFER.
- T_OFFER: id_valid[t]=1 with id stable. On id_valid & id_ready -> T_SERVICE, and id_valid drops the next cycle.
- T_SERVICE -> T_CMPL_REQ on done[t]. done in any other state is ignored.
- T_CMPL_REQ: waits for the grant and the APB write, which takes PWDATA = zero-extended latched ID.
  - At write completion go to T_IDLE and load holdoff[t] = HOLDOFF.
  - PSLVERR on the write is ignored.
- holdoff[t] decrements once per cycle while nonzero in T_IDLE. It prevents re-claiming on a stale irq.

Arbiter:
- Complete requests have strict priority over claim requests.
- Round-robin applies within each class. The pointer moves to one past the granted target, wrapping from TARGETS-1 to 0.
- A grant is issued only when the APB FSM is IDLE; requests are sampled in that same cycle.

APB master FSM:
- A_IDLE -> A_SETUP (PSEL=1, PENABLE=0) on a grant. Address, direction and data are registered at the grant and held stable through ACCESS.
- A_SETUP -> A_ACCESS (PSEL=1, PENABLE=1).
- A_ACCESS holds until PREADY=1, then -> A_IDLE.
  - PSEL/PENABLE are 0 in the cycle after PREADY.
  - PRDATA and PSLVERR are sampled at PREADY.
- Address: CLAIM_BASE + t*CLAIM_STRIDE, computed in PADDR_SIZE bits with wrap-around allowed.
- PSTRB is all-ones on writes and all-zeros on reads. PWDATA is 0 on reads.
- Minimum transfer is 2 cycles. With zero-wait slaves a full claim+offer+complete round uses at least 5 cycles of bus plus consumer latency.
- No back-to-back transfers: at least 1 A_IDLE cycle between transfers.

Simultaneous events:
- done and a grant in the same cycle: both register; the grant belongs to another target.
- irq deasserting during T_CLAIM_REQ still performs the read. A result of 0 returns to idle.
- Only one APB transfer is ever outstanding.

Decomposition:
- Package plic_claim_pkg holds:
  - target-state enum {T_IDLE, T_CLAIM_REQ, T_OFFER, T_SERVICE, T_CMPL_REQ};
  - APB-state enum {A_IDLE, A_SETUP, A_ACCESS};
  - the HOLDOFF counter width constant (4).
- Sub-module plic_rr_arbiter (parameter N): request vector in, one-hot grant out, pointer update on an accept strobe. It is instantiated twice, once for complete requests and once for claims.

Test Plan:
1. irq[1]=1, PRDATA=5, PREADY=1 → read at 32'h0020_1004 with PSEL high 2 cycles; id_valid[1]=1 with id slice1=5; after id_ready and then done, a write to 32'h0020_1004 with PWDATA=5 and PSTRB=4'hF.
2. irq[0], irq[2], irq[3] all rise in the same cycle, each read returning a nonzero ID → claims issue in order 0, 2, 3; the pointer then favours 0 again only after 3.
3. Target 2 is in T_CMPL_REQ while target 0 is in T_CLAIM_REQ → the complete write to target 2 is granted first.
4. Claim read returns 0 → no id_valid and target returns to idle; with irq still 1 a new claim starts once holdoff has expired.
5. PREADY held low 3 cycles in ACCESS → PADDR, PWRITE and PWDATA stay stable; the transfer ends 1 cycle after PREADY=1.
6. PRESET asserted during A_ACCESS → the next cycle has PSEL=0, id_valid=0 and all FSMs idle; irq then re-triggers a fresh claim.
